// File: rtl/serial_sub8_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

    localparam int SUB_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_sub8_if.sv
// Start/done handshake plus operand and result bundle for serial_sub8.
interface serial_sub8_if #(
    parameter int WIDTH = sub_pkg::SUB_WIDTH_DEFAULT
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
    logic             zero;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, borrow, ovf, zero
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, borrow, ovf, zero
    );
endinterface

// File: rtl/serial_sub8_fs.sv
// One-bit full subtractor cell; outputs first to match the full_adder port order.
module full_subtractor (
    output logic diff,
    output logic bout,
    input  logic a,
    input  logic b,
    input  logic bin
);
    always_comb begin
        diff = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end
endmodule

// File: rtl/serial_sub8.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor cell and a registered borrow.
//
//   state | meaning
//   IDLE  | waiting for start, outputs hold last result
//   SHIFT | one operand bit consumed per clock
//   DONE  | one-cycle done pulse; start accepted here too
module serial_sub8
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    serial_sub8_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    sub_state_t       state, state_nxt;
    logic             accept;
    logic             last;

    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;

    logic             fs_d;
    logic             fs_bout;
    logic [WIDTH-1:0] res_nxt;

    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             ovf_q;
    logic             zero_q;

    full_subtractor u_fs (
        .diff (fs_d),
        .bout (fs_bout),
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .bin  (br)
    );

    assign res_nxt = {fs_d, res[WIDTH-1:1]};

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sh_a     <= '0;
            sh_b     <= '0;
            res      <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                sh_a  <= bus.a;
                sh_b  <= bus.b;
                br    <= bus.bin;
                cnt   <= '0;
                a_msb <= bus.a[WIDTH-1];
                b_msb <= bus.b[WIDTH-1];
            end else if (state == SHIFT) begin
                sh_a <= sh_a >> 1;
                sh_b <= sh_b >> 1;
                br   <= fs_bout;
                res  <= res_nxt;
                cnt  <= cnt + CW'(1);
                // Flags are only published on the final bit so they hold across the next run.
                if (last) begin
                    diff_q   <= res_nxt;
                    borrow_q <= fs_bout;
                    ovf_q    <= (a_msb != b_msb) && (res_nxt[WIDTH-1] != a_msb);
                    zero_q   <= (res_nxt == '0);
                end
            end
        end
    end

    assign bus.busy   = (state == SHIFT);
    assign bus.done   = (state == DONE);
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
    assign bus.ovf    = ovf_q;
    assign bus.zero   = zero_q;

endmodule
